// File: rtl/lab5_counter.sv
// Run/pause/step 3-bit digit counter with prescaled auto-advance.
// Buttons are synchronized and edge-detected into one-cycle press pulses.
module lab5_counter #(
  parameter int unsigned DIV_MAX = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       dir_down,
  input  logic       clr,
  output logic [2:0] cnt,
  output logic       tick,
  output logic       wrap,
  output logic [1:0] state
);

  localparam int unsigned PW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [PW-1:0] TERM = PW'(DIV_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t        cur, nxt;
  logic [PW-1:0] presc, presc_n;
  logic [2:0]    cnt_n;
  logic          tick_n, wrap_n;

  // [0],[1] synchronizer stages, [2] previous synchronized level
  logic [2:0] run_sh, step_sh;
  logic [1:0] vld;
  logic       run_armed, step_armed;
  logic       run_p, step_p;

  // A button seen high once the synchronizer holds real data must be seen
  // low before it may pulse, so a press held through reset is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sh     <= '0;
      step_sh    <= '0;
      vld        <= '0;
      run_armed  <= 1'b0;
      step_armed <= 1'b0;
    end else begin
      run_sh     <= {run_sh[1:0], btn_run};
      step_sh    <= {step_sh[1:0], btn_step};
      vld        <= {vld[0], 1'b1};
      run_armed  <= run_armed  | (vld[1] & ~run_sh[1]);
      step_armed <= step_armed | (vld[1] & ~step_sh[1]);
    end
  end

  assign run_p  = run_sh[1]  & ~run_sh[2]  & run_armed;
  assign step_p = step_sh[1] & ~step_sh[2] & step_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= IDLE;
      cnt   <= '0;
      presc <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      cur   <= nxt;
      cnt   <= cnt_n;
      presc <= presc_n;
      tick  <= tick_n;
      wrap  <= wrap_n;
    end
  end

  always_comb begin
    logic adv;
    nxt     = cur;
    cnt_n   = cnt;
    presc_n = presc;
    tick_n  = 1'b0;
    adv     = 1'b0;

    if (clr) begin
      nxt     = IDLE;
      cnt_n   = '0;
      presc_n = '0;
    end else begin
      unique case (cur)
        IDLE: begin
          cnt_n   = '0;
          presc_n = '0;
          if (run_p) begin
            nxt = RUN;
          end else if (step_p) begin
            adv = 1'b1;
            nxt = PAUSE;
          end
        end
        RUN: begin
          if (presc == TERM) begin
            presc_n = '0;
            // A pause request on the terminal cycle wins over the advance
            if (run_p) begin
              nxt = PAUSE;
            end else begin
              adv    = 1'b1;
              tick_n = 1'b1;
            end
          end else begin
            presc_n = presc + PW'(1);
            if (run_p) nxt = PAUSE;
          end
        end
        PAUSE: begin
          if (run_p) begin
            nxt = RUN;
          end else if (step_p) begin
            adv = 1'b1;
          end
        end
        default: begin
          nxt     = IDLE;
          cnt_n   = '0;
          presc_n = '0;
        end
      endcase
    end

    wrap_n = 1'b0;
    if (adv) begin
      if (dir_down) begin
        cnt_n  = cnt - 3'd1;
        wrap_n = (cnt == 3'd0);
      end else begin
        cnt_n  = cnt + 3'd1;
        wrap_n = (cnt == 3'd7);
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_lab5_counter.sv
// Directed bench for lab5_counter with DIV_MAX=4.
module tb_lab5_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_step = 1'b0;
  logic       dir_down = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] cnt;
  logic       tick;
  logic       wrap;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  lab5_counter #(.DIV_MAX(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .dir_down (dir_down),
    .clr      (clr),
    .cnt      (cnt),
    .tick     (tick),
    .wrap     (wrap),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise at a falling edge; effect is visible after the 3rd rising edge.
  task automatic press_run();
    btn_run = 1'b1;
    repeat (3) @(negedge clk);
    btn_run = 1'b0;
  endtask

  task automatic press_step();
    btn_step = 1'b1;
    repeat (3) @(negedge clk);
    btn_step = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_cnt", 32'(cnt), 0);
    chk("reset_state", 32'(state), 0);
    chk("reset_tick", 32'(tick), 0);
    chk("reset_wrap", 32'(wrap), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Free-running count up, one advance per 4 cycles
    press_run();
    chk("run_state", 32'(state), 1);
    chk("run_cnt0", 32'(cnt), 0);
    for (int k = 1; k <= 8; k++) begin
      repeat (3) @(negedge clk);
      chk("up_tick_low", 32'(tick), 0);
      @(negedge clk);
      chk("up_tick", 32'(tick), 1);
      chk("up_cnt", 32'(cnt), 32'(k % 8));
      chk("up_wrap", 32'(wrap), (k == 8) ? 1 : 0);
    end

    // Reverse direction at cnt=2
    repeat (8) @(negedge clk);
    chk("cnt_at_2", 32'(cnt), 2);
    dir_down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      chk("down_tick", 32'(tick), 1);
      chk("down_cnt", 32'(cnt), 32'((9 - i) % 8));
      chk("down_wrap", 32'(wrap), (i == 2) ? 1 : 0);
    end
    dir_down = 1'b0;

    // Pause when the prescaler reads 2, resume after 10 cycles
    press_run();
    chk("pause_state", 32'(state), 2);
    chk("pause_tick", 32'(tick), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("pause_cnt_frozen", 32'(cnt), 7);
    end
    press_run();
    chk("resume_state", 32'(state), 1);
    chk("resume_tick_low", 32'(tick), 0);
    @(negedge clk);
    chk("resume_tick", 32'(tick), 1);
    chk("resume_cnt", 32'(cnt), 0);
    chk("resume_wrap", 32'(wrap), 1);

    // Back to IDLE, then single steps
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_idle", 32'(state), 0);
    repeat (3) @(negedge clk);
    for (int s = 1; s <= 3; s++) begin
      press_step();
      chk("step_state", 32'(state), 2);
      chk("step_cnt", 32'(cnt), 32'(s));
      chk("step_tick", 32'(tick), 0);
      repeat (3) @(negedge clk);
    end

    // Step press while running is ignored
    press_run();
    chk("step_run_state", 32'(state), 1);
    press_step();
    chk("run_step_ignored", 32'(cnt), 3);
    @(negedge clk);
    chk("run_step_tick", 32'(tick), 1);
    chk("run_step_cnt", 32'(cnt), 4);

    // Simultaneous run and step from IDLE
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr2_cnt", 32'(cnt), 0);
    repeat (3) @(negedge clk);
    btn_run  = 1'b1;
    btn_step = 1'b1;
    repeat (3) @(negedge clk);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    chk("both_state", 32'(state), 1);
    chk("both_cnt", 32'(cnt), 0);
    repeat (20) @(negedge clk);
    chk("pre_clr_cnt", 32'(cnt), 5);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_state", 32'(state), 0);
    chk("clr_cnt", 32'(cnt), 0);
    chk("clr_tick", 32'(tick), 0);

    // Asynchronous reset mid-run with the run button held
    repeat (3) @(negedge clk);
    press_run();
    repeat (24) @(negedge clk);
    chk("pre_rst_cnt", 32'(cnt), 6);
    btn_run = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_cnt", 32'(cnt), 0);
    chk("async_state", 32'(state), 0);
    chk("async_tick", 32'(tick), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("held_btn_idle", 32'(state), 0);
    btn_run = 1'b0;
    repeat (4) @(negedge clk);
    press_run();
    chk("repress_run", 32'(state), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
